// File: rtl/ddr3_ui_arbiter.sv
// ddr3_ui_arbiter
//   Two-requester round-robin scheduler in front of ddr3_ui. It accepts one
//   transfer request at a time and latches its parameters. It then launches
//   the transfer with a go strobe and follows the ddr3_ui busy/fault
//   handshake. When the transfer ends, it returns done/fault to the
//   requester that owns it.
//
//   State | meaning
//   IDLE  | waiting for calibration and a request; arbitration happens here
//   START | go strobe held until ddr3_ui reports busy (or start timeout)
//   RUN   | transfer in flight; waiting for busy to fall (or watchdog)
//   DONE  | completion pulse to owner, rr pointer and transfer count update
//
// Ports
//   ui_clk, rst                       clock, synchronous active-high reset
//   i_app_phy_init_done               grants allowed only while high
//   i_req / i_req_wr                  per-requester request level and direction
//   i_req_ddr3_addr/_count/_buf_addr  packed per-requester transfer parameters
//   o_ack / o_done / o_fault          per-requester handshake pulses
//   o_busy, o_grant_id                in-flight flag, owner of current/last transfer
//   o_ibuf_go / o_obuf_go             launch strobes (write / read)
//   o_count / o_buf_addr / o_ddr3_addr latched transfer parameters
//   i_ibuf_bsy / i_obuf_bsy           busy from ddr3_ui
//   i_ibuf_ddr3_fault / i_obuf_ddr3_fault  fault from ddr3_ui
//   o_xfer_cnt                        good-transfer counter, saturating
module ddr3_ui_arbiter #(
    parameter int BUF_DEPTH      = 10,
    parameter int MEM_ADDR_DEPTH = 28,
    parameter int START_TIMEOUT  = 16,
    parameter int WDOG_CYCLES    = 65535
) (
    input  logic                          ui_clk,
    input  logic                          rst,
    input  logic                          i_app_phy_init_done,
    input  logic [1:0]                    i_req,
    input  logic [1:0]                    i_req_wr,
    input  logic [2*MEM_ADDR_DEPTH-1:0]   i_req_ddr3_addr,
    input  logic [2*BUF_DEPTH-1:0]        i_req_count,
    input  logic [2*BUF_DEPTH-1:0]        i_req_buf_addr,
    output logic [1:0]                    o_ack,
    output logic [1:0]                    o_done,
    output logic [1:0]                    o_fault,
    output logic                          o_busy,
    output logic                          o_grant_id,
    output logic                          o_ibuf_go,
    output logic                          o_obuf_go,
    output logic [BUF_DEPTH-1:0]          o_count,
    output logic [BUF_DEPTH-1:0]          o_buf_addr,
    output logic [MEM_ADDR_DEPTH-1:0]     o_ddr3_addr,
    input  logic                          i_ibuf_bsy,
    input  logic                          i_obuf_bsy,
    input  logic                          i_ibuf_ddr3_fault,
    input  logic                          i_obuf_ddr3_fault,
    output logic [15:0]                   o_xfer_cnt
);

    localparam int TW = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_t;

    state_t                    state_q, state_d;
    logic                      rr_q, rr_d;          // last requester served
    logic                      owner_q, owner_d;
    logic                      wr_q, wr_d;
    logic                      fault_q, fault_d;
    logic [BUF_DEPTH-1:0]      count_q, count_d;
    logic [BUF_DEPTH-1:0]      buf_q, buf_d;
    logic [MEM_ADDR_DEPTH-1:0] addr_q, addr_d;
    logic [TW-1:0]             tmr_q, tmr_d;
    logic [15:0]               wdog_q, wdog_d;
    logic [15:0]               xfer_q, xfer_d;
    logic [1:0]                ack_q, ack_d;
    logic [1:0]                done_q, done_d;
    logic [1:0]                flt_q, flt_d;
    logic                      igo_q, igo_d;
    logic                      ogo_q, ogo_d;

    // Winner: a lone requester wins; on a tie the one not served last wins.
    logic                      win;
    logic                      sel_wr;
    logic [BUF_DEPTH-1:0]      sel_count;
    logic [BUF_DEPTH-1:0]      sel_buf;
    logic [MEM_ADDR_DEPTH-1:0] sel_addr;
    logic                      bsy_sel;
    logic                      flt_sel;

    assign win       = (i_req == 2'b10) || ((i_req == 2'b11) && !rr_q);
    assign sel_wr    = win ? i_req_wr[1] : i_req_wr[0];
    assign sel_count = win ? i_req_count[2*BUF_DEPTH-1:BUF_DEPTH] : i_req_count[BUF_DEPTH-1:0];
    assign sel_buf   = win ? i_req_buf_addr[2*BUF_DEPTH-1:BUF_DEPTH] : i_req_buf_addr[BUF_DEPTH-1:0];
    assign sel_addr  = win ? i_req_ddr3_addr[2*MEM_ADDR_DEPTH-1:MEM_ADDR_DEPTH]
                           : i_req_ddr3_addr[MEM_ADDR_DEPTH-1:0];
    assign bsy_sel   = wr_q ? i_ibuf_bsy : i_obuf_bsy;
    assign flt_sel   = wr_q ? i_ibuf_ddr3_fault : i_obuf_ddr3_fault;

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        owner_d = owner_q;
        wr_d    = wr_q;
        fault_d = fault_q;
        count_d = count_q;
        buf_d   = buf_q;
        addr_d  = addr_q;
        tmr_d   = tmr_q;
        wdog_d  = wdog_q;
        xfer_d  = xfer_q;
        ack_d   = 2'b00;
        done_d  = 2'b00;
        flt_d   = 2'b00;
        igo_d   = 1'b0;
        ogo_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_app_phy_init_done && (i_req != 2'b00)) begin
                    owner_d = win;
                    wr_d    = sel_wr;
                    count_d = sel_count;
                    buf_d   = sel_buf;
                    addr_d  = sel_addr;
                    if (win) ack_d = 2'b10;
                    else     ack_d = 2'b01;
                    if (sel_count == '0) begin
                        // Nothing to move: complete as a fault without touching ddr3_ui.
                        fault_d = 1'b1;
                        state_d = DONE;
                    end else begin
                        fault_d = 1'b0;
                        tmr_d   = TW'(START_TIMEOUT - 1);
                        igo_d   = sel_wr;
                        ogo_d   = !sel_wr;
                        state_d = START;
                    end
                end
            end
            START: begin
                // Go falls on the edge that samples busy high, so it never
                // overlaps busy long enough to retrigger ddr3_ui.
                if (bsy_sel) begin
                    wdog_d  = 16'(WDOG_CYCLES);
                    state_d = RUN;
                end else if (tmr_q == '0) begin
                    fault_d = 1'b1;
                    state_d = DONE;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                    igo_d = wr_q;
                    ogo_d = !wr_q;
                end
            end
            RUN: begin
                if (!bsy_sel) begin
                    fault_d = flt_sel;
                    state_d = DONE;
                end else if (wdog_q <= 16'd1) begin
                    fault_d = 1'b1;
                    state_d = DONE;
                end else begin
                    wdog_d = wdog_q - 16'd1;
                end
            end
            DONE: begin
                if (owner_q) begin
                    done_d = 2'b10;
                    flt_d  = {fault_q, 1'b0};
                end else begin
                    done_d = 2'b01;
                    flt_d  = {1'b0, fault_q};
                end
                rr_d = owner_q;
                if (!fault_q && (xfer_q != 16'hFFFF)) xfer_d = xfer_q + 16'd1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ui_clk) begin
        if (rst) begin
            state_q <= IDLE;
            rr_q    <= 1'b1;
            owner_q <= 1'b0;
            wr_q    <= 1'b0;
            fault_q <= 1'b0;
            count_q <= '0;
            buf_q   <= '0;
            addr_q  <= '0;
            tmr_q   <= '0;
            wdog_q  <= '0;
            xfer_q  <= '0;
            ack_q   <= '0;
            done_q  <= '0;
            flt_q   <= '0;
            igo_q   <= 1'b0;
            ogo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            wr_q    <= wr_d;
            fault_q <= fault_d;
            count_q <= count_d;
            buf_q   <= buf_d;
            addr_q  <= addr_d;
            tmr_q   <= tmr_d;
            wdog_q  <= wdog_d;
            xfer_q  <= xfer_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
            flt_q   <= flt_d;
            igo_q   <= igo_d;
            ogo_q   <= ogo_d;
        end
    end

    assign o_ack       = ack_q;
    assign o_done      = done_q;
    assign o_fault     = flt_q;
    assign o_busy      = (state_q != IDLE);
    assign o_grant_id  = owner_q;
    assign o_ibuf_go   = igo_q;
    assign o_obuf_go   = ogo_q;
    assign o_count     = count_q;
    assign o_buf_addr  = buf_q;
    assign o_ddr3_addr = addr_q;
    assign o_xfer_cnt  = xfer_q;

endmodule

// File: tb/tb_ddr3_ui_arbiter.sv
// Testbench for ddr3_ui_arbiter: a behavioural ddr3_ui busy model,
// directed stimulus, and a scoreboard monitor for ack/done events.
module tb_ddr3_ui_arbiter;

    localparam int B = 10;
    localparam int M = 28;

    logic           ui_clk = 1'b0;
    logic           rst;
    logic           init_done;
    logic [1:0]     req, req_wr;
    logic [2*M-1:0] req_addr;
    logic [2*B-1:0] req_count, req_buf;
    logic [1:0]     ack, done, fault;
    logic           busy, grant_id, ibuf_go, obuf_go;
    logic [B-1:0]   count, buf_addr;
    logic [M-1:0]   ddr3_addr;
    logic           ibuf_bsy, obuf_bsy, ibuf_flt, obuf_flt;
    logic [15:0]    xfer_cnt;

    ddr3_ui_arbiter dut (
        .ui_clk(ui_clk), .rst(rst), .i_app_phy_init_done(init_done),
        .i_req(req), .i_req_wr(req_wr), .i_req_ddr3_addr(req_addr),
        .i_req_count(req_count), .i_req_buf_addr(req_buf),
        .o_ack(ack), .o_done(done), .o_fault(fault), .o_busy(busy),
        .o_grant_id(grant_id), .o_ibuf_go(ibuf_go), .o_obuf_go(obuf_go),
        .o_count(count), .o_buf_addr(buf_addr), .o_ddr3_addr(ddr3_addr),
        .i_ibuf_bsy(ibuf_bsy), .i_obuf_bsy(obuf_bsy),
        .i_ibuf_ddr3_fault(ibuf_flt), .i_obuf_ddr3_fault(obuf_flt),
        .o_xfer_cnt(xfer_cnt)
    );

    always #5 ui_clk = ~ui_clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [1:0]  done;
        logic [1:0]  fault;
        logic [15:0] xfer;
    } exp_t;

    logic [1:0] exp_ack[$];
    exp_t       exp_done[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    // ddr3_ui busy model: busy rises bsy_delay cycles after go is seen,
    // stays high bsy_len cycles, and falls with the configured fault.
    int  bsy_delay = 2;
    int  bsy_len   = 30;
    bit  bsy_never = 1'b0;
    bit  bsy_fault = 1'b0;

    always begin
        logic m_wr;
        @(negedge ui_clk);
        if (!rst && (ibuf_go || obuf_go) && !bsy_never) begin
            m_wr = ibuf_go;
            repeat (bsy_delay) @(negedge ui_clk);
            chk("go_held_until_bsy", 64'(m_wr ? ibuf_go : obuf_go), 64'd1);
            if (m_wr) ibuf_bsy = 1'b1; else obuf_bsy = 1'b1;
            @(negedge ui_clk);
            chk("go_dropped_after_bsy", 64'(ibuf_go | obuf_go), 64'd0);
            repeat (bsy_len - 1) @(negedge ui_clk);
            ibuf_bsy = 1'b0;
            obuf_bsy = 1'b0;
            if (m_wr) ibuf_flt = bsy_fault; else obuf_flt = bsy_fault;
            @(negedge ui_clk);
            ibuf_flt = 1'b0;
            obuf_flt = 1'b0;
        end
    end

    // Scoreboard monitor.
    always @(negedge ui_clk) begin
        if (!rst) begin
            if (ack != 2'b00) begin
                if (exp_ack.size() == 0) chk("unexpected_ack", 64'(ack), 64'd0);
                else chk("ack_id", 64'(ack), 64'(exp_ack.pop_front()));
            end
            if (done != 2'b00) begin
                if (exp_done.size() == 0) chk("unexpected_done", 64'(done), 64'd0);
                else begin
                    exp_t e;
                    e = exp_done.pop_front();
                    chk("done_id", 64'(done), 64'(e.done));
                    chk("done_fault", 64'(fault), 64'(e.fault));
                    chk("xfer_cnt", 64'(xfer_cnt), 64'(e.xfer));
                end
            end else if (fault != 2'b00) begin
                chk("fault_without_done", 64'(fault), 64'd0);
            end
        end
    end

    task automatic push_exp(input logic [1:0] a, input logic [1:0] d, input logic [1:0] f,
                            input logic [15:0] x);
        exp_t e;
        e.done  = d;
        e.fault = f;
        e.xfer  = x;
        exp_ack.push_back(a);
        exp_done.push_back(e);
    endtask

    task automatic wait_ack(output int lat);
        lat = 0;
        while (lat < 200) begin
            @(negedge ui_clk);
            if (ack != 2'b00) break;
            lat++;
        end
        if (lat >= 200) timeout_fail("ack_timeout");
    endtask

    task automatic drain(input int budget, output bit saw_go);
        int n;
        n = 0;
        saw_go = 1'b0;
        while ((exp_ack.size() != 0 || exp_done.size() != 0) && n < budget) begin
            @(negedge ui_clk);
            if (ibuf_go || obuf_go) saw_go = 1'b1;
            n++;
        end
        if (exp_ack.size() != 0 || exp_done.size() != 0) begin
            timeout_fail("done_timeout");
            exp_ack.delete();
            exp_done.delete();
        end
        chk("idle_after_done", 64'(busy), 64'd0);
    endtask

    task automatic check_all_zero(input string name);
        chk(name, {ack, done, fault, busy, grant_id, ibuf_go, obuf_go, xfer_cnt}, 64'd0);
        chk({name, "_latched"}, {count, buf_addr, ddr3_addr}, 64'd0);
    endtask

    initial begin
        int lat;
        bit saw_go;
        bit bad;
        int n;

        rst = 1'b1; init_done = 1'b0; req = 2'b00; req_wr = 2'b00;
        req_addr = '0; req_count = '0; req_buf = '0;
        ibuf_bsy = 1'b0; obuf_bsy = 1'b0; ibuf_flt = 1'b0; obuf_flt = 1'b0;
        repeat (4) @(negedge ui_clk);
        check_all_zero("reset_outputs");
        rst = 1'b0;

        // Request while uncalibrated: no grant, no go.
        req = 2'b01; req_wr = 2'b01;
        req_addr = {28'h0, 28'h100}; req_count = {10'd0, 10'd8}; req_buf = '0;
        bad = 1'b0;
        repeat (20) begin
            @(negedge ui_clk);
            if (ack != 2'b00 || ibuf_go || obuf_go || busy) bad = 1'b1;
        end
        chk("no_grant_uninit", 64'(bad), 64'd0);

        // Calibration completes: req0 write, good transfer.
        push_exp(2'b01, 2'b01, 2'b00, 16'd1);
        init_done = 1'b1;
        wait_ack(lat);
        chk("ack_latency", 64'(lat), 64'd0);
        req = 2'b00;
        chk("latched_addr", 64'(ddr3_addr), 64'h100);
        chk("latched_count", 64'(count), 64'd8);
        chk("latched_buf", 64'(buf_addr), 64'd0);
        chk("grant_id0", 64'(grant_id), 64'd0);
        chk("wr_go", 64'({ibuf_go, obuf_go}), 64'b10);
        drain(200, saw_go);

        // req1 read, busy never rises: start timeout after 16 go cycles.
        bsy_never = 1'b1;
        req = 2'b10; req_wr = 2'b00;
        req_addr = {28'h0ABCDE0, 28'h0}; req_count = {10'd5, 10'd0}; req_buf = {10'd33, 10'd0};
        push_exp(2'b10, 2'b10, 2'b10, 16'd1);
        wait_ack(lat);
        req = 2'b00;
        chk("grant_id1", 64'(grant_id), 64'd1);
        n = 0;
        while (obuf_go && n < 100) begin
            n++;
            @(negedge ui_clk);
        end
        chk("go_cycles_before_timeout", 64'(n), 64'd16);
        drain(50, saw_go);
        bsy_never = 1'b0;

        // Both requesting continuously: grants alternate 0,1,0,1.
        req = 2'b11; req_wr = 2'b11;
        req_addr = {28'h0222000, 28'h0111000}; req_count = {10'd4, 10'd4};
        req_buf = {10'd64, 10'd16};
        push_exp(2'b01, 2'b01, 2'b00, 16'd2);
        push_exp(2'b10, 2'b10, 2'b00, 16'd3);
        push_exp(2'b01, 2'b01, 2'b00, 16'd4);
        push_exp(2'b10, 2'b10, 2'b00, 16'd5);
        for (int k = 0; k < 4; k++) begin
            wait_ack(lat);
            chk("rr_addr", 64'(ddr3_addr), (k % 2 == 1) ? 64'h0222000 : 64'h0111000);
        end
        req = 2'b00;
        drain(200, saw_go);

        // req1 read with a ddr3_ui fault: fault reported, count unchanged.
        bsy_fault = 1'b1;
        req = 2'b10; req_wr = 2'b00;
        push_exp(2'b10, 2'b10, 2'b10, 16'd5);
        wait_ack(lat);
        req = 2'b00;
        drain(200, saw_go);
        bsy_fault = 1'b0;

        // req0 count 0: ack and faulted done, no go strobe.
        req = 2'b01; req_wr = 2'b01; req_count = {10'd4, 10'd0};
        push_exp(2'b01, 2'b01, 2'b01, 16'd5);
        wait_ack(lat);
        req = 2'b00;
        if (ibuf_go || obuf_go) saw_go = 1'b1;
        else drain(20, saw_go);
        chk("no_go_count0", 64'(saw_go), 64'd0);

        // Reset during RUN: everything clears, no done.
        bsy_len = 40;
        req = 2'b01; req_wr = 2'b01; req_count = {10'd4, 10'd3};
        exp_ack.push_back(2'b01);
        wait_ack(lat);
        req = 2'b00;
        repeat (6) @(negedge ui_clk);
        chk("busy_in_run", 64'(busy), 64'd1);
        rst = 1'b1;
        @(negedge ui_clk);
        check_all_zero("reset_in_run");
        repeat (3) @(negedge ui_clk);
        rst = 1'b0;
        repeat (50) @(negedge ui_clk);
        check_all_zero("after_reset_in_run");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
